ahb_bus_arbiter: RTL
====================

// Module: ahb_bus_arbiter
// PURPOSE
//  Two-master AHB-Lite arbiter. Shares the system AHB bus between M0 (Cortex-M3 core) and M1 (DMA engine).
//  Drives the grants and the address-phase owner index (HMASTER), which feed the master-side address/control mux.
//  Tracks the data-phase owner (HMASTER_D). HMASTER_D steers the returned HREADY/HRDATA from the slave read mux.
//  Never re-arbitrates inside a fixed-length burst or a locked sequence.
// PARAMETERS
//  ROUND_ROBIN     1   1 = alternate between masters on contention; 0 = fixed priority, M0 wins
//  DEFAULT_MASTER  0   master granted at reset and parked on when no master requests
//  MAX_HOLD        16  max consecutive accepted SINGLE/INCR beats while the other master waits; then force handover
// PORTS
//  HCLK         in   1  system clock
//  HRESET       in   1  asynchronous, active-high reset
//  HBUSREQ_M0   in   1  bus request, M0
//  HBUSREQ_M1   in   1  bus request, M1
//  HTRANS_M0    in   2  M0 transfer type
//  HTRANS_M1    in   2  M1 transfer type
//  HBURST_M0    in   3  M0 burst type
//  HBURST_M1    in   3  M1 burst type
//  HLOCK_M0     in   1  M0 lock request (AHB_ARB_LOCK_EN only)
//  HLOCK_M1     in   1  M1 lock request (AHB_ARB_LOCK_EN only)
//  HREADY       in   1  system HREADY, returned from the slave read mux
//  HGRANT_M0    out  1  grant to M0 (registered)
//  HGRANT_M1    out  1  grant to M1 (registered)
//  HMASTER      out  1  address-phase owner index
//  HMASTER_D    out  1  data-phase owner index
//  HMASTLOCK    out  1  current address phase is locked
// BEHAVIOUR
//  Reset (HRESET=1, immediate; also mid-burst)
//   - HGRANT_M<DEFAULT_MASTER>=1, other grant 0; HMASTER=HMASTER_D=DEFAULT_MASTER
//   - HMASTLOCK=0; beat counter=0; hold counter=0; last_served=~DEFAULT_MASTER; FSM=ARB
//  Stall
//   - All registers update only on rising HCLK with HREADY=1. HREADY=0 freezes everything.
//  Ownership, per HREADY=1 edge
//   - HMASTER<=index of the current HGRANT; HMASTER_D<=HMASTER.
//   - Latency: new grant -> HMASTER one edge later -> HMASTER_D one edge after that.
//  FSM states: ARB, BURST, LOCKED. "Owner signals" = HTRANS/HBURST of the master selected by HMASTER.
//   - ARB: HGRANT re-evaluated every HREADY=1 edge.
//     - Both request: ROUND_ROBIN=1 grants ~last_served; ROUND_ROBIN=0 grants M0.
//     - One requests: grant it. None requests: park on DEFAULT_MASTER.
//     - last_served updates when a grant changes.
//   - ARB->BURST: owner issues NONSEQ (10) with HBURST>=WRAP4.
//     - Load beat count - 1: WRAP4/INCR4 (010/011)=3; WRAP8/INCR8 (100/101)=7; WRAP16/INCR16 (110/111)=15.
//     - HGRANT frozen while in BURST.
//   - BURST:
//     - SEQ (11): decrement the counter. BUSY (01): hold the counter.
//     - Accepting SEQ at count 1 (last beat): ->ARB, and HGRANT is re-evaluated on that same edge.
//     - IDLE or NONSEQ before completion (early termination): ->ARB, re-evaluate on that edge.
//   - SINGLE/INCR (000/001): stay in ARB.
//     - Hold counter increments per accepted NONSEQ/SEQ while the other master requests; clears otherwise.
//     - Reaching MAX_HOLD forces the grant to the waiting master regardless of priority; the counter then clears.
//   - Outgoing master gets one address cycle after losing HGRANT and must drive IDLE in it (one-cycle handover bubble).
//  HBUSREQ drop mid-burst: ignored; the burst completes.
//  Simultaneous burst start and new request: the burst wins; the request is served at the burst-end edge.
// CONFIGURATION
//  AHB_ARB_LOCK_EN defined:
//   - HLOCK_M0/M1 present.
//   - Granted master with HBUSREQ=1 and HLOCK=1 at an HREADY=1 edge enters LOCKED (from ARB, or from BURST at burst end).
//   - LOCKED: HGRANT held; MAX_HOLD ignored. Exit to ARB on the first HREADY=1 edge with owner HLOCK=0 and HTRANS != BUSY.
//   - HMASTLOCK<=owner HLOCK on HREADY=1 edges, aligned with HMASTER.
//  AHB_ARB_LOCK_EN undefined: HLOCK ports absent; LOCKED unreachable; HMASTLOCK tied 0.
// TESTING
//  - Reset:
//    - HRESET=1 mid INCR8 -> HGRANT_M0=1, HGRANT_M1=0, HMASTER=0, HMASTER_D=0, HMASTLOCK=0 without waiting for a clock edge.
//  - Round robin (ROUND_ROBIN=1):
//    - Both request SINGLE, HREADY=1 -> HGRANT sequence M0,M1,M0,M1 on successive edges.
//    - HMASTER lags the grant by 1 edge, HMASTER_D by 2.
//  - Fixed-length burst:
//    - M0 INCR8; M1 requests at beat 2 -> HGRANT_M1 rises only at the edge accepting beat 8.
//    - HMASTER=1 one HREADY edge later.
//  - Wait states:
//    - HREADY=0 for 3 cycles at beat 4 of WRAP4 -> counter, HGRANT, HMASTER, HMASTER_D unchanged.
//    - Handover after the 4th accepted beat.
//  - Early termination / hold limit:
//    - M0 INCR4 then IDLE after beat 2 -> M1 granted on that edge.
//    - MAX_HOLD=4, M0 INCR stream, M1 requesting -> grant moves to M1 after 4 accepted beats.
//  - Lock (AHB_ARB_LOCK_EN):
//    - M1 HLOCK=1, M0 requests 10 cycles -> HGRANT_M1 held, HMASTLOCK=1.
//    - HLOCK_M1 drops -> M0 granted on the next HREADY=1 edge; HMASTLOCK=0.

Source files
------------

// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB-Lite arbiter: grants, address/data-phase owner tracking, burst and lock protection.
// Optional bus locking is compiled in with the macro AHB_ARB_LOCK_EN.
module ahb_bus_arbiter #(
  parameter int ROUND_ROBIN    = 1,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 16
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HBUSREQ_M0,
  input  logic       HBUSREQ_M1,
  input  logic [1:0] HTRANS_M0,
  input  logic [1:0] HTRANS_M1,
  input  logic [2:0] HBURST_M0,
  input  logic [2:0] HBURST_M1,
`ifdef AHB_ARB_LOCK_EN
  input  logic       HLOCK_M0,
  input  logic       HLOCK_M1,
`endif
  input  logic       HREADY,
  output logic       HGRANT_M0,
  output logic       HGRANT_M1,
  output logic       HMASTER,
  output logic       HMASTER_D,
  output logic       HMASTLOCK
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic DEF_M = (DEFAULT_MASTER != 0);
  localparam logic RR_EN = (ROUND_ROBIN != 0);
  localparam int   HW    = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_BURST  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic          grant_reg, grant_next;
  logic          last_served_reg, last_served_next;
  logic          hmaster_reg, hmaster_next;
  logic          hmaster_d_reg, hmaster_d_next;
  logic [3:0]    beat_cnt_reg, beat_cnt_next;
  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;

  logic [1:0] req;
  logic [1:0] lock_req;
  logic [1:0] owner_trans;
  logic [2:0] owner_burst;
  logic       beat_accepted;
  logic       burst_start;
  logic       lock_enter;
  logic       hold_event;
  logic       arb_grant;
  logic       arb_valid;
  logic       do_arb;
  logic       use_hold;
  logic [3:0] beat_load;

  assign req = {HBUSREQ_M1, HBUSREQ_M0};

`ifdef AHB_ARB_LOCK_EN
  assign lock_req = {HLOCK_M1, HLOCK_M0};
`else
  assign lock_req = 2'b00;
`endif

  // Transfer qualifiers always come from the address-phase owner, not the grantee.
  assign owner_trans   = hmaster_reg ? HTRANS_M1 : HTRANS_M0;
  assign owner_burst   = hmaster_reg ? HBURST_M1 : HBURST_M0;
  assign beat_accepted = (owner_trans == TR_NONSEQ) || (owner_trans == TR_SEQ);
  assign burst_start   = (owner_trans == TR_NONSEQ) && (owner_burst >= 3'b010);
  assign lock_enter    = req[grant_reg] && lock_req[grant_reg];
  assign hold_event    = beat_accepted && req[~grant_reg] && (hmaster_reg == grant_reg);

  always_comb begin
    beat_load = 4'd15;
    case (owner_burst)
      3'b010, 3'b011: beat_load = 4'd3;
      3'b100, 3'b101: beat_load = 4'd7;
      default:        beat_load = 4'd15;
    endcase
  end

  always_comb begin
    arb_valid = |req;
    arb_grant = DEF_M;
    if (req[0] && req[1]) begin
      arb_grant = RR_EN ? ~last_served_reg : 1'b0;
    end else if (req[0]) begin
      arb_grant = 1'b0;
    end else if (req[1]) begin
      arb_grant = 1'b1;
    end
  end

  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    last_served_next = last_served_reg;
    hmaster_next     = hmaster_reg;
    hmaster_d_next   = hmaster_d_reg;
    beat_cnt_next    = beat_cnt_reg;
    hold_cnt_next    = hold_cnt_reg;
    do_arb           = 1'b0;
    use_hold         = 1'b0;
    if (HREADY) begin
      hmaster_next   = grant_reg;
      hmaster_d_next = hmaster_reg;
      unique case (state_reg)
        ST_ARB: begin
          if (burst_start) begin
            state_next       = ST_BURST;
            beat_cnt_next    = beat_load;
            last_served_next = hmaster_reg;
            hold_cnt_next    = '0;
          end else if (lock_enter) begin
            state_next    = ST_LOCKED;
            hold_cnt_next = '0;
          end else begin
            do_arb   = 1'b1;
            use_hold = 1'b1;
          end
        end
        ST_BURST: begin
          if (owner_trans == TR_BUSY) begin
            beat_cnt_next = beat_cnt_reg;
          end else if ((owner_trans == TR_SEQ) && (beat_cnt_reg != 4'd1)) begin
            beat_cnt_next = beat_cnt_reg - 4'd1;
          end else if (lock_enter) begin
            // Last beat or early termination: either lock or hand back to arbitration.
            state_next = ST_LOCKED;
          end else begin
            state_next = ST_ARB;
            do_arb     = 1'b1;
          end
        end
        ST_LOCKED: begin
          if ((hmaster_reg == grant_reg) && !lock_req[hmaster_reg] &&
              (owner_trans != TR_BUSY)) begin
            state_next = ST_ARB;
            do_arb     = 1'b1;
          end
        end
        default: state_next = ST_ARB;
      endcase

      if (do_arb) begin
        hold_cnt_next = '0;
        if (use_hold && hold_event && (hold_cnt_reg == HOLD_LAST)) begin
          grant_next       = ~grant_reg;
          last_served_next = ~grant_reg;
        end else begin
          grant_next = arb_grant;
          if (arb_valid) begin
            last_served_next = arb_grant;
          end
          if (use_hold && hold_event && (arb_grant == grant_reg)) begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_reg       <= ST_ARB;
      grant_reg       <= DEF_M;
      last_served_reg <= ~DEF_M;
      hmaster_reg     <= DEF_M;
      hmaster_d_reg   <= DEF_M;
      beat_cnt_reg    <= 4'd0;
      hold_cnt_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      last_served_reg <= last_served_next;
      hmaster_reg     <= hmaster_next;
      hmaster_d_reg   <= hmaster_d_next;
      beat_cnt_reg    <= beat_cnt_next;
      hold_cnt_reg    <= hold_cnt_next;
    end
  end

`ifdef AHB_ARB_LOCK_EN
  logic hmastlock_reg;

  // Lock indication follows the grantee so it lines up with HMASTER.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      hmastlock_reg <= 1'b0;
    end else if (HREADY) begin
      hmastlock_reg <= lock_req[grant_reg];
    end
  end

  assign HMASTLOCK = hmastlock_reg;
`else
  assign HMASTLOCK = 1'b0;
`endif

  assign HGRANT_M0 = ~grant_reg;
  assign HGRANT_M1 = grant_reg;
  assign HMASTER   = hmaster_reg;
  assign HMASTER_D = hmaster_d_reg;

endmodule
